// File: rtl/uart_tx_mmio_pkg.sv
// ============================================================================
// Module  : uart_tx_mmio_pkg
// Brief   : Shared types, register map and FSM encoding for the MMIO UART TX.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_tx_mmio_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] value;
    logic [1:0]      width;
    logic            enable;
  } mem_write_control_t;

  localparam logic [XLEN-1:0] C_TXDATA_OFF = 32'h0000_0000;
  localparam logic [XLEN-1:0] C_STATUS_OFF = 32'h0000_0004;

  localparam int C_STATUS_BUSY_BIT  = 0;
  localparam int C_STATUS_FULL_BIT  = 1;
  localparam int C_STATUS_EMPTY_BIT = 2;
  localparam int C_STATUS_OVF_BIT   = 3;
  localparam int C_STATUS_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
// ============================================================================
// Module  : uart_tx_mmio_if
// Brief   : MMIO port bundle between the data-memory stage and the UART TX.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_tx_mmio_if;
  import uart_tx_mmio_pkg::*;

  mem_write_control_t io_control;
  logic [XLEN-1:0]    io_r_data;

  modport master (output io_control, input  io_r_data);
  modport slave  (input  io_control, output io_r_data);
endinterface

`default_nettype wire

// File: rtl/uart_tx_mmio_fifo.sv
// ============================================================================
// Module  : sync_fifo
// Brief   : Single-clock FIFO, power-of-two depth, push-when-full allowed
//           only together with a pop.
// Revision: 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     push,
  input  wire logic                     pop,
  input  wire logic [width-1:0]         w_data,
  output logic      [width-1:0]         r_data,
  output logic                          full,
  output logic                          empty,
  output logic      [$clog2(depth):0]   count
);

  localparam int AW = $clog2(depth);

  logic [width-1:0] mem_q [depth];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (AW+1)'(depth));
  assign count     = count_q;
  assign r_data    = mem_q[rd_ptr_q];
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (w_push_ok) mem_q[wr_ptr_q] <= w_data;
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_mmio.sv
// ============================================================================
// Module  : uart_tx_mmio
// Brief   : Memory-mapped 8N1 UART transmitter with a byte FIFO and status.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter logic [XLEN-1:0] base_addr      = 32'h0001_0000,
  parameter int              clocks_per_bit = 434,
  parameter int              fifo_depth     = 8
) (
  input  wire logic         clock,
  input  wire logic         reset,
  uart_tx_mmio_if.slave     bus,
  output logic              tx
);

  localparam int BW = $clog2(clocks_per_bit);
  localparam int CW = $clog2(fifo_depth) + 1;

  tx_state_e       state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            ovf_q, ovf_d;

  logic            w_wr_tx, w_wr_status;
  logic            w_push, w_pop;
  logic            w_full, w_empty, w_busy, w_baud_last;
  logic [7:0]      w_head;
  logic [CW-1:0]   w_count;
  logic [7:0]      w_count8;

  assign w_wr_tx     = bus.io_control.enable && (bus.io_control.addr == base_addr + C_TXDATA_OFF);
  assign w_wr_status = bus.io_control.enable && (bus.io_control.addr == base_addr + C_STATUS_OFF);
  assign w_push      = w_wr_tx && (!w_full || w_pop);
  assign w_baud_last = (baud_q == BW'(clocks_per_bit - 1));

  sync_fifo #(.width(8), .depth(fifo_depth)) u_fifo (
    .clock  (clock),
    .reset  (reset),
    .push   (w_push),
    .pop    (w_pop),
    .w_data (bus.io_control.value[7:0]),
    .r_data (w_head),
    .full   (w_full),
    .empty  (w_empty),
    .count  (w_count)
  );

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    w_pop   = 1'b0;
    tx      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        idx_d  = '0;
        if (!w_empty) begin
          w_pop   = 1'b1;
          shift_d = w_head;
          state_d = ST_START;
        end
      end
      ST_START: begin
        tx = 1'b0;
        if (w_baud_last) begin
          baud_d  = '0;
          idx_d   = '0;
          state_d = ST_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_DATA: begin
        tx = shift_q[idx_q];
        if (w_baud_last) begin
          baud_d = '0;
          if (idx_q == 3'd7) state_d = ST_STOP;
          else               idx_d   = idx_q + 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame so queued bytes leave gap-free.
          if (!w_empty) begin
            w_pop   = 1'b1;
            shift_d = w_head;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A dropped byte outranks a simultaneous clear request.
  always_comb begin
    ovf_d = ovf_q;
    if (w_wr_status && bus.io_control.value[C_STATUS_OVF_BIT]) ovf_d = 1'b0;
    if (w_wr_tx && w_full && !w_pop)                           ovf_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_busy   = (state_q != ST_IDLE) || !w_empty;
  assign w_count8 = 8'(w_count);

  always_comb begin
    bus.io_r_data = '0;
    if (bus.io_control.addr == base_addr + C_STATUS_OFF) begin
      bus.io_r_data = {16'b0, w_count8, 4'b0, ovf_q, w_empty, w_full, w_busy};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
// ============================================================================
// Module  : tb_uart_tx_mmio
// Brief   : Directed self-checking bench for uart_tx_mmio (4 clk/bit, depth 4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_mmio;
  import uart_tx_mmio_pkg::*;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_BAD = BASE + 32'h8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  int   n_checks = 0;
  int   n_errors = 0;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .base_addr      (BASE),
    .clocks_per_bit (4),
    .fifo_depth     (4)
  ) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k);
    int s;
    s = k / 4;
    if (s == 0) return 1'b0;
    if (s >= 9) return 1'b1;
    return b[s-1];
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] v, input logic en);
    bus.io_control.addr   = a;
    bus.io_control.value  = v;
    bus.io_control.width  = 2'b10;
    bus.io_control.enable = en;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    drive(a, v, 1'b1);
    cyc(1);
    drive(A_ST, 32'h0, 1'b0);
  endtask

  initial begin
    int bad;
    logic [7:0] b;
    drive(A_ST, 32'h0, 1'b0);
    rst = 1'b1;
    cyc(2);
    #1;
    check("rst_tx", 32'(tx), 32'h1);
    check("rst_status", bus.io_r_data, 32'h0000_0004);
    drive(A_TX, 32'h0, 1'b0);
    #1 check("rst_txdata_rd", bus.io_r_data, 32'h0);
    drive(A_ST, 32'h0, 1'b0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    // Single byte 0x55 from idle
    wr(A_TX, 32'h55);
    #1;
    check("t1_pre_tx", 32'(tx), 32'h1);
    check("t1_pre_status", bus.io_r_data, 32'h0000_0101);
    for (int k = 0; k < 40; k++) begin
      cyc(1);
      check($sformatf("t1_bit%0d", k), 32'(tx), 32'(exp_bit(8'h55, k)));
    end
    cyc(1);
    #1 check("t1_done_status", bus.io_r_data, 32'h0000_0004);

    // Six back-to-back writes: five sent gap-free, sixth dropped
    for (int i = 1; i <= 6; i++) begin
      drive(A_TX, 32'(i), 1'b1);
      cyc(1);
    end
    drive(A_ST, 32'h0, 1'b0);
    #1 check("t2_status", bus.io_r_data, 32'h0000_040B);
    for (int k = 4; k < 200; k++) begin
      b = 8'(k / 40 + 1);
      check($sformatf("t2_k%0d", k), 32'(tx), 32'(exp_bit(b, k % 40)));
      cyc(1);
    end
    #1 check("t2_done_status", bus.io_r_data, 32'h0000_000C);

    // Clear sticky overflow
    wr(A_ST, 32'h8);
    #1 check("t3_ovf_clr", bus.io_r_data, 32'h0000_0004);

    // Queue while a frame is active; overflow then clear next cycle
    wr(A_TX, 32'hA5);
    cyc(2);
    drive(A_TX, 32'h11, 1'b1); cyc(1);
    drive(A_TX, 32'h22, 1'b1); cyc(1);
    drive(A_TX, 32'h33, 1'b1); cyc(1);
    drive(A_ST, 32'h0, 1'b0);
    #1 check("t4_count3", bus.io_r_data, 32'h0000_0301);
    drive(A_BAD, 32'h0, 1'b0);
    #1 check("t4_bad_addr", bus.io_r_data, 32'h0);
    drive(A_TX, 32'h0, 1'b0);
    #1 check("t4_txdata_rd", bus.io_r_data, 32'h0);
    drive(A_TX, 32'h44, 1'b1); cyc(1);
    drive(A_TX, 32'h66, 1'b1); cyc(1);
    drive(A_ST, 32'h0, 1'b0);
    #1 check("t4_ovf_set", bus.io_r_data, 32'h0000_040B);
    drive(A_ST, 32'h8, 1'b1); cyc(1);
    drive(A_ST, 32'h0, 1'b0);
    #1 check("t4_ovf_clr", bus.io_r_data, 32'h0000_0403);
    for (int k = 8; k < 44; k++) begin
      cyc(1);
      if (k < 40) check($sformatf("t4_k%0d", k), 32'(tx), 32'(exp_bit(8'hA5, k)));
      else        check($sformatf("t4_k%0d", k), 32'(tx), 32'(exp_bit(8'h11, k - 40)));
    end
    for (int i = 0; i < 400 && bus.io_r_data[0]; i++) cyc(1);
    #1 check("t4_drain_busy", 32'(bus.io_r_data[0]), 32'h0);
    check("t4_drain_status", bus.io_r_data, 32'h0000_0004);

    // Reset mid-frame with two bytes queued
    cyc(1);
    drive(A_TX, 32'hC3, 1'b1); cyc(1);
    drive(A_TX, 32'h3C, 1'b1); cyc(1);
    drive(A_TX, 32'h5A, 1'b1); cyc(1);
    drive(A_ST, 32'h0, 1'b0);
    #1 check("t5_queued", bus.io_r_data, 32'h0000_0201);
    cyc(14);
    #1 check("t5_pre_rst_tx", 32'(tx), 32'(exp_bit(8'hC3, 15)));
    rst = 1'b1;
    #1;
    check("t5_rst_tx", 32'(tx), 32'h1);
    check("t5_rst_status", bus.io_r_data, 32'h0000_0004);
    cyc(2);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      cyc(1);
      if (tx !== 1'b1) bad++;
    end
    check("t5_no_frames", 32'(bad), 32'h0);
    #1 check("t5_final_status", bus.io_r_data, 32'h0000_0004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
